text_stream_encoder: RTL and testbench

Producer side of the text display's letter-write interface: accepts ASCII bytes over a valid/ready handshake and emits 5-bit glyph codes as single-cycle `data_valid_out` strobes, one per text-buffer cell. Tracks the write position in the 1024-cell (32 columns × 32 rows) text buffer so that it can expand newline into row padding and form-feed into a full clear. Optionally generates the display's scroll commands. Sits between the UART/keyboard front end and the text display, in the same clock domain as the display's write port.

---
 rtl/text_stream_encoder_pkg.sv | 34 +++
 rtl/text_stream_encoder_glyph_map.sv | 37 +++
 rtl/text_stream_encoder.sv | 163 ++++++++++++++++
 tb/tb_text_stream_encoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/text_stream_encoder_pkg.sv
// Shared constants and types for the text stream encoder.
// Optional feature macro: TEXT_AUTO_SCROLL_EN (adds the SCROLL_UP state).
package text_pkg;

   localparam logic [4:0] GLYPH_SPACE   = 5'd26;
   localparam logic [4:0] GLYPH_PERIOD  = 5'd27;
   localparam logic [4:0] GLYPH_COMMA   = 5'd28;
   localparam logic [4:0] GLYPH_UNKNOWN = 5'd29;

   localparam logic [7:0] ASCII_NEWLINE  = 8'h0A;
   localparam logic [7:0] ASCII_FORMFEED = 8'h0C;

`ifdef TEXT_AUTO_SCROLL_EN
   typedef enum logic [1:0] {
      StIdle,
      StPad,
      StClear,
      StScrollUp
   } enc_state_e;
`else
   typedef enum logic [1:0] {
      StIdle,
      StPad,
      StClear
   } enc_state_e;
`endif

   typedef enum logic [1:0] {
      ScrollHold = 2'd0,
      ScrollDown = 2'd1,
      ScrollUp   = 2'd2
   } scroll_dir_t;

endpackage

// File: rtl/text_stream_encoder_glyph_map.sv
// Combinational ASCII-to-glyph decoder with printable / newline / form-feed flags.
module ascii_glyph_map
   import text_pkg::*;
(
   input  logic [7:0] ascii_i,
   output logic [4:0] glyph_o,
   output logic       printable_o,
   output logic       newline_o,
   output logic       formfeed_o
);

   logic [7:0] offset;

   // Letters of either case share codes 0-25; other printables collapse to a few glyphs
   always_comb begin
      offset  = 8'h00;
      glyph_o = GLYPH_UNKNOWN;
      if (ascii_i >= 8'h41 && ascii_i <= 8'h5A) begin
         offset  = ascii_i - 8'h41;
         glyph_o = offset[4:0];
      end else if (ascii_i >= 8'h61 && ascii_i <= 8'h7A) begin
         offset  = ascii_i - 8'h61;
         glyph_o = offset[4:0];
      end else if (ascii_i == 8'h20) begin
         glyph_o = GLYPH_SPACE;
      end else if (ascii_i == 8'h2E) begin
         glyph_o = GLYPH_PERIOD;
      end else if (ascii_i == 8'h2C) begin
         glyph_o = GLYPH_COMMA;
      end
   end

   assign printable_o = (ascii_i >= 8'h20) && (ascii_i <= 8'h7E);
   assign newline_o   = (ascii_i == ASCII_NEWLINE);
   assign formfeed_o  = (ascii_i == ASCII_FORMFEED);

endmodule

// File: rtl/text_stream_encoder.sv
// Text stream encoder: ASCII bytes in, one glyph strobe per text-buffer cell out.
// Newline pads the current row with spaces, form feed clears to the end of the buffer.
// Optional feature macro: TEXT_AUTO_SCROLL_EN (display scroll commands + SCROLL_UP state).
module text_stream_encoder
   import text_pkg::*;
#(
   parameter int unsigned COLS     = 32,
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned VIS_ROWS = 16
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic                       ascii_valid_in,
   input  logic [7:0]                 ascii_in,
   output logic                       ascii_ready_out,
   output logic                       data_valid_out,
   output logic [4:0]                 data_out,
   output logic [1:0]                 scroll_dir_out,
   output logic [$clog2(DEPTH)-1:0]   pos_out
);

   localparam int unsigned PosW       = $clog2(DEPTH);
   localparam int unsigned ColW       = $clog2(COLS);
   localparam int unsigned ScrollRows = DEPTH / COLS - VIS_ROWS;

   enc_state_e       state_q, state_d;
   logic [PosW-1:0]  pos_q, pos_d;
   logic             valid_q, valid_d;
   logic [4:0]       data_q, data_d;
   logic             ready_q, ready_d;

   logic [4:0]       map_glyph;
   logic             map_printable;
   logic             map_newline;
   logic             map_formfeed;
   logic             xfer;
   logic             emit;
   logic [4:0]       emit_glyph;

   ascii_glyph_map u_glyph_map (
      .ascii_i     (ascii_in),
      .glyph_o     (map_glyph),
      .printable_o (map_printable),
      .newline_o   (map_newline),
      .formfeed_o  (map_formfeed)
   );

   assign xfer = ascii_valid_in && ready_q;

`ifdef TEXT_AUTO_SCROLL_EN
   localparam int unsigned CntW = $clog2(ScrollRows + 1);
   scroll_dir_t      scroll_q, scroll_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
`endif

   // Next-state: the first pad/clear space issues on the transfer itself so the
   // strobe lands one cycle after the byte; the fill states exit one cycle after
   // their last strobe, which keeps ready low through that final strobe.
   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      valid_d    = 1'b0;
      data_d     = data_q;
      emit       = 1'b0;
      emit_glyph = GLYPH_SPACE;
`ifdef TEXT_AUTO_SCROLL_EN
      scroll_d   = ScrollHold;
      cnt_d      = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (xfer) begin
               if (map_printable) begin
                  emit       = 1'b1;
                  emit_glyph = map_glyph;
               end else if (map_newline && (pos_q[ColW-1:0] != '0)) begin
                  emit    = 1'b1;
                  state_d = StPad;
               end else if (map_formfeed) begin
                  emit    = 1'b1;
                  state_d = StClear;
               end
            end
         end
         StPad: begin
            if (pos_q[ColW-1:0] != '0) emit = 1'b1;
            else                       state_d = StIdle;
         end
         StClear: begin
            if (pos_q != '0) emit = 1'b1;
            else             state_d = StIdle;
         end
`ifdef TEXT_AUTO_SCROLL_EN
         StScrollUp: begin
            if (cnt_q != CntW'(ScrollRows)) begin
               scroll_d = ScrollUp;
               cnt_d    = cnt_q + 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
`endif
         default: state_d = StIdle;
      endcase

      if (emit) begin
         valid_d = 1'b1;
         data_d  = emit_glyph;
         pos_d   = pos_q + 1'b1;
`ifdef TEXT_AUTO_SCROLL_EN
         if (pos_d == '0) begin
            state_d = StScrollUp;
            cnt_d   = '0;
         end else if ((pos_d[ColW-1:0] == '0) &&
                      (32'(pos_d[PosW-1:ColW]) >= VIS_ROWS)) begin
            scroll_d = ScrollDown;
         end
`endif
      end

      ready_d = (state_d == StIdle);
   end

   // State and registered outputs
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= StIdle;
         pos_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         ready_q <= ready_d;
      end
   end

`ifdef TEXT_AUTO_SCROLL_EN
   // Scroll command register and SCROLL_UP row counter
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         scroll_q <= ScrollHold;
         cnt_q    <= '0;
      end else begin
         scroll_q <= scroll_d;
         cnt_q    <= cnt_d;
      end
   end

   assign scroll_dir_out = scroll_q;
`else
   assign scroll_dir_out = ScrollHold;
`endif

   assign ascii_ready_out = ready_q;
   assign data_valid_out  = valid_q;
   assign data_out        = data_q;
   assign pos_out         = pos_q;

endmodule

// File: tb/tb_text_stream_encoder.sv
// Directed bench for text_stream_encoder (default build, auto-scroll disabled).
module tb_text_stream_encoder;

   logic       clk;
   logic       rst_n;
   logic       ascii_valid;
   logic [7:0] ascii;
   logic       ready;
   logic       dvalid;
   logic [4:0] dout;
   logic [1:0] scroll;
   logic [9:0] pos;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   text_stream_encoder dut (
      .clk_in          (clk),
      .rst_n_in        (rst_n),
      .ascii_valid_in  (ascii_valid),
      .ascii_in        (ascii),
      .ascii_ready_out (ready),
      .data_valid_out  (dvalid),
      .data_out        (dout),
      .scroll_dir_out  (scroll),
      .pos_out         (pos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b;
      logic       exp_v;
      logic [4:0] exp_g;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else n_pass++;
   endtask

   // Called at a negedge; returns at the next negedge with the strobe visible
   task automatic send_byte(input logic [7:0] b);
      ascii_valid = 1'b1;
      ascii       = b;
      @(negedge clk);
      ascii_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int unsigned exp_pos;
      int unsigned strobes;
      int unsigned low_cycles;
      int unsigned bad_glyph;
      bit          done;

      vecs[0]  = '{8'h07, 1'b0, 5'd0};
      vecs[1]  = '{8'h7F, 1'b0, 5'd0};
      vecs[2]  = '{8'h09, 1'b0, 5'd0};
      vecs[3]  = '{8'h23, 1'b1, 5'd29};  // '#'
      vecs[4]  = '{8'h41, 1'b1, 5'd0};   // 'A'
      vecs[5]  = '{8'h7A, 1'b1, 5'd25};  // 'z'
      vecs[6]  = '{8'h20, 1'b1, 5'd26};  // ' '
      vecs[7]  = '{8'h2C, 1'b1, 5'd28};  // ','
      vecs[8]  = '{8'h3F, 1'b1, 5'd29};  // '?'
      vecs[9]  = '{8'h7E, 1'b1, 5'd29};  // '~'
      vecs[10] = '{8'h80, 1'b0, 5'd0};
      vecs[11] = '{8'hFF, 1'b0, 5'd0};
      vecs[12] = '{8'h61, 1'b1, 5'd0};   // 'a'
      vecs[13] = '{8'h5A, 1'b1, 5'd25};  // 'Z'

      rst_n       = 1'b0;
      ascii_valid = 1'b0;
      ascii       = 8'h00;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 0);
      check("rst_valid", dvalid, 0);
      check("rst_data", dout, 0);
      check("rst_scroll", scroll, 0);
      check("rst_pos", pos, 0);
      rst_n = 1'b1;
      #1 check("ready_before_edge", ready, 0);
      @(negedge clk);
      check("ready_after_release", ready, 1);

      // "Hi." back to back
      send_byte(8'h48);
      check("H_valid", dvalid, 1);
      check("H_glyph", dout, 7);
      send_byte(8'h69);
      check("i_valid", dvalid, 1);
      check("i_glyph", dout, 8);
      send_byte(8'h2E);
      check("dot_valid", dvalid, 1);
      check("dot_glyph", dout, 27);
      check("hi_pos", pos, 3);
      @(negedge clk);
      check("idle_valid", dvalid, 0);

      // Single-byte glyph / drop table
      exp_pos = 3;
      for (int i = 0; i < 14; i++) begin
         send_byte(vecs[i].b);
         if (vecs[i].exp_v) exp_pos = (exp_pos + 1) % 1024;
         check($sformatf("vec%0d_valid", i), dvalid, vecs[i].exp_v);
         if (vecs[i].exp_v) check($sformatf("vec%0d_glyph", i), dout, vecs[i].exp_g);
         check($sformatf("vec%0d_pos", i), pos, exp_pos);
         check($sformatf("vec%0d_ready", i), ready, 1);
      end

      // "AB" + newline from a fresh reset
      do_reset();
      send_byte(8'h41);
      check("A_glyph", dout, 0);
      send_byte(8'h42);
      check("B_glyph", dout, 1);
      send_byte(8'h0A);
      strobes = 0; low_cycles = 0; bad_glyph = 0; done = 0;
      check("nl_first_strobe", dvalid, 1);
      for (int c = 0; c < 100 && !done; c++) begin
         if (ready) begin
            done = 1;
         end else begin
            low_cycles++;
            if (dvalid) begin
               strobes++;
               if (dout != 5'd26) bad_glyph++;
            end
            @(negedge clk);
         end
      end
      check("nl_done_in_time", done, 1);
      check("nl_strobes", strobes, 30);
      check("nl_ready_low", low_cycles, 30);
      check("nl_pad_glyph_errors", bad_glyph, 0);
      check("nl_pos", pos, 32);
      check("nl_scroll", scroll, 0);

      // Newline at col 0 (pos 64) is a no-op
      for (int i = 0; i < 32; i++) send_byte(8'h78);
      check("pos64", pos, 64);
      send_byte(8'h0A);
      check("nl0_valid", dvalid, 0);
      check("nl0_ready", ready, 1);
      @(negedge clk);
      check("nl0_ready_next", ready, 1);
      check("nl0_pos", pos, 64);

      // Form feed at pos 1000
      for (int i = 0; i < 936; i++) send_byte(8'h71);
      check("pos1000", pos, 1000);
      send_byte(8'h0C);
      strobes = 0; low_cycles = 0; done = 0;
      for (int c = 0; c < 2000 && !done; c++) begin
         if (ready) begin
            done = 1;
         end else begin
            low_cycles++;
            if (dvalid) strobes++;
            @(negedge clk);
         end
      end
      check("ff_done_in_time", done, 1);
      check("ff_strobes", strobes, 24);
      check("ff_ready_low", low_cycles, 24);
      check("ff_pos", pos, 0);

      // Async reset in the middle of a full clear
      send_byte(8'h0C);
      repeat (9) @(negedge clk);
      check("clr_mid_valid", dvalid, 1);
      check("clr_mid_glyph", dout, 26);
      check("clr_mid_ready", ready, 0);
      check("clr_mid_pos", pos, 10);
      #2 rst_n = 1'b0;
      #1;
      check("async_ready", ready, 0);
      check("async_valid", dvalid, 0);
      check("async_data", dout, 0);
      check("async_pos", pos, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", ready, 1);
      check("post_rst_pos", pos, 0);
      send_byte(8'h7A);
      check("z_valid", dvalid, 1);
      check("z_glyph", dout, 25);
      check("z_pos", pos, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
